cpu_trace_monitor: RTL
======================

CPU_TRACE_MONITOR -- requirements
Module: cpu_trace_monitor

Interface
REQ-001 Parameter DEPTH, 16, trace buffer entries; power of two, minimum 2.
REQ-002 Parameter WRAP, 1, full-buffer policy: 1 = overwrite the oldest entry, 0 = drop the new entry.
REQ-003 Parameter HALT_PC, 32'h000000ff, committed PC that ends the run.
REQ-004 Parameter MAX_CYCLES, 1000, timeout in RUN cycles; 0 disables the timeout.
REQ-005 Parameter NREG, 32, number of registers walked in DUMP (1..32).
REQ-006 Clocking: one clock; reset is asynchronous and active-low (clk, rstn).
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rstn  in  1  asynchronous active-low reset.
REQ-009 commit  in  1  one instruction retires this cycle.
REQ-010 pc  in  32  PC of the retiring instruction.
REQ-011 instr  in  32  retiring instruction word.
REQ-012 reg_sel  out  5  register file debug select.
REQ-013 reg_data  in  32  register file data for reg_sel, combinational, same cycle.
REQ-014 rd_en  in  1  pop the oldest trace entry.
REQ-015 rd_valid  out  1  trace buffer non-empty.
REQ-016 rd_pc, rd_instr  out  32 each  oldest entry, first-word-fall-through.
REQ-017 count  out  $clog2(DEPTH)+1  number of valid entries.
REQ-018 overflow  out  1  sticky: an entry was lost (overwritten or dropped).
REQ-019 halted  out  1  the run has ended.
REQ-020 halt_cause  out  2  01 = PC match, 10 = timeout, 00 = running.
REQ-021 cycle_cnt  out  32  RUN cycles elapsed.
REQ-022 dump_valid, dump_idx(5), dump_data(32)  out  one register-dump beat per cycle.
REQ-023 dump_done  out  1  register walk complete.

Function
REQ-024 FSM states are RUN -> DUMP -> DONE; DONE is terminal until reset.
REQ-025 RUN: cycle_cnt +1 every cycle; a commit writes {pc,instr} at the tail.
REQ-026 RUN to DUMP occurs on the edge where commit=1 and pc==HALT_PC. The halting entry is still recorded. halted=1, halt_cause=01 from the next cycle.
REQ-027 RUN to DUMP also occurs when MAX_CYCLES!=0 and cycle_cnt==MAX_CYCLES-1. The counter ends at MAX_CYCLES and halt_cause=10. If both conditions hit on the same edge, PC match wins (01).
REQ-028 In DUMP and DONE, commit is ignored and cycle_cnt is frozen.
REQ-029 Push when full, WRAP=1: the oldest entry is overwritten, head advances, count stays DEPTH, overflow set.
REQ-030 Push when full, WRAP=0: the entry is discarded, state unchanged, overflow set.
REQ-031 Pop: rd_en with count>0 advances head and decrements count; rd_en with count==0 is ignored.
REQ-032 Simultaneous push and pop: count unchanged, no overflow, even when full.
REQ-033 Pointers wrap modulo DEPTH; rd_* are don't-care while rd_valid=0.
REQ-034 Trace reads are allowed in all states.
REQ-035 DUMP walk: reg_sel = ptr, with ptr starting at 0. Each cycle registers dump_idx<=ptr, dump_data<=(ptr==0 ? 0 : reg_data), dump_valid<=1, then ptr+1.
REQ-036 After the beat for ptr==NREG-1, the FSM enters DONE. Next cycle: dump_valid=0, dump_done=1 (sticky).
REQ-037 reg_sel is 0 outside DUMP.

Reset
REQ-038 While rstn=0, asynchronously force:
- state RUN; head, tail, count = 0;
- overflow, halted, dump_valid, dump_done = 0;
- halt_cause, cycle_cnt, reg_sel, dump_idx, dump_data = 0.
Buffer contents need no reset.
REQ-039 Reset asserted mid-DUMP or mid-run aborts immediately. The first RUN cycle follows the first rising edge after rstn deasserts.

Verification
REQ-040 Commits at pc 0,4,8 then pc=0xff -> count=4; rd_pc pops 0,4,8,ff; halted=1, halt_cause=01 the cycle after the 0xff commit.
REQ-041 WRAP=1, DEPTH=4, 6 commits pc=1..6, no reads -> count=4, rd_pc sequence 3,4,5,6, overflow=1. With WRAP=0 the sequence is 1,2,3,4, overflow=1.
REQ-042 Full buffer with commit and rd_en on the same edge -> count stays 4, overflow stays 0, newest entry is at the tail.
REQ-043 MAX_CYCLES=10, no halt PC -> halted after 10 RUN cycles, cycle_cnt=10, halt_cause=10. With pc==HALT_PC on that same edge -> halt_cause=01.
REQ-044 Halt, then reg_data=reg_sel*16 -> 32 dump beats idx 0..31. data[0]=0, data[7]=0x70. dump_done=1 one cycle after idx 31.
REQ-045 rstn low for one half-cycle during DUMP beat 5 -> all outputs 0 at once; RUN resumes, count=0, cycle_cnt restarts from 0.

Source files
------------

// File: rtl/cpu_trace_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_trace_monitor: commit-trace FIFO, halt/timeout detection and a       |
// | post-halt register-file dump walk.                                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cpu_trace_monitor #(
    parameter int          DEPTH      = 16,
    parameter int          WRAP       = 1,
    parameter logic [31:0] HALT_PC    = 32'h000000ff,
    parameter int          MAX_CYCLES = 1000,
    parameter int          NREG       = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     commit,
    input  logic [31:0]              pc,
    input  logic [31:0]              instr,
    output logic [4:0]               reg_sel,
    input  logic [31:0]              reg_data,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [31:0]              rd_pc,
    output logic [31:0]              rd_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     halted,
    output logic [1:0]               halt_cause,
    output logic [31:0]              cycle_cnt,
    output logic                     dump_valid,
    output logic [4:0]               dump_idx,
    output logic [31:0]              dump_data,
    output logic                     dump_done
);

    localparam int          AW           = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT     = (AW+1)'(DEPTH);
    localparam logic [4:0]  LAST_REG     = 5'(NREG - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(MAX_CYCLES - 1);
    localparam bit          TIMEOUT_EN   = (MAX_CYCLES != 0);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_DUMP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          halted_q;
    logic [1:0]    halt_cause_q;
    logic [31:0]   cycle_cnt_q;
    logic [4:0]    reg_sel_q;
    logic          dump_valid_q;
    logic [4:0]    dump_idx_q;
    logic [31:0]   dump_data_q;
    logic          dump_done_q;
    logic [63:0]   mem_q [DEPTH];

    logic w_push, w_pop, w_full, w_wr_en;

    always_comb begin
        w_full     = (count_q == FULL_CNT);
        w_push     = (state_q == S_RUN) && commit;
        w_pop      = rd_en && (count_q != '0);
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        w_wr_en    = 1'b0;
        // A concurrent pop frees the slot the push lands in, so no loss even when full.
        if (w_push && w_pop) begin
            w_wr_en = 1'b1;
            tail_d  = tail_q + 1'b1;
            head_d  = head_q + 1'b1;
        end else if (w_push && !w_full) begin
            w_wr_en = 1'b1;
            tail_d  = tail_q + 1'b1;
            count_d = count_q + 1'b1;
        end else if (w_push) begin
            overflow_d = 1'b1;
            if (WRAP != 0) begin
                w_wr_en = 1'b1;
                tail_d  = tail_q + 1'b1;
                head_d  = head_q + 1'b1;
            end
        end else if (w_pop) begin
            head_d  = head_q + 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[tail_q] <= {pc, instr};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_RUN;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            halted_q     <= 1'b0;
            halt_cause_q <= 2'b00;
            cycle_cnt_q  <= '0;
            reg_sel_q    <= '0;
            dump_valid_q <= 1'b0;
            dump_idx_q   <= '0;
            dump_data_q  <= '0;
            dump_done_q  <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            case (state_q)
                S_RUN: begin
                    cycle_cnt_q <= cycle_cnt_q + 1'b1;
                    if (commit && (pc == HALT_PC)) begin
                        state_q      <= S_DUMP;
                        halted_q     <= 1'b1;
                        halt_cause_q <= 2'b01;
                    end else if (TIMEOUT_EN && (cycle_cnt_q == TIMEOUT_LAST)) begin
                        state_q      <= S_DUMP;
                        halted_q     <= 1'b1;
                        halt_cause_q <= 2'b10;
                    end
                end
                S_DUMP: begin
                    // Register 0 reads as zero regardless of the file's output.
                    dump_idx_q   <= reg_sel_q;
                    dump_data_q  <= (reg_sel_q == 5'd0) ? 32'd0 : reg_data;
                    dump_valid_q <= 1'b1;
                    if (reg_sel_q == LAST_REG) begin
                        state_q   <= S_DONE;
                        reg_sel_q <= '0;
                    end else begin
                        reg_sel_q <= reg_sel_q + 1'b1;
                    end
                end
                S_DONE: begin
                    dump_valid_q <= 1'b0;
                    dump_done_q  <= 1'b1;
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    assign reg_sel    = reg_sel_q;
    assign rd_valid   = (count_q != '0);
    assign rd_pc      = mem_q[head_q][63:32];
    assign rd_instr   = mem_q[head_q][31:0];
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign halted     = halted_q;
    assign halt_cause = halt_cause_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign dump_valid = dump_valid_q;
    assign dump_idx   = dump_idx_q;
    assign dump_data  = dump_data_q;
    assign dump_done  = dump_done_q;

endmodule
`default_nettype wire
